// File: rtl/game_sequencer.sv
// Play-flow controller: idle -> datapath clear -> count-in -> play -> done, gating beat_tick into beat_step.
// Optional pause/re-count-in support is enabled by defining MUSEDASH_PAUSE_EN.
module game_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int CHART_LEN   = 4096,
  parameter int COUNT_BEATS = 4,
  parameter int CLR_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_tick,
  input  logic              start,
  input  logic              pause,
  input  logic              chart_end,
  output logic              beat_step,
  output logic              dp_clr_n,
  output logic [ADDR_W-1:0] beat_idx,
  output logic [3:0]        count_val,
  output logic [2:0]        state,
  output logic              done
);

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam logic [CLR_W-1:0]  CLR_LAST   = CLR_W'(CLR_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(CHART_LEN - 1);
  localparam logic [3:0]        COUNT_INIT = 4'(COUNT_BEATS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_COUNT = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [3:0]        count_reg, count_next;
  logic [CLR_W-1:0]  clr_reg, clr_next;
  logic              step_reg, step_next;
  logic              start_q;
  logic              start_rise;
  logic              pause_rise;
  logic              go_clear;

  assign start_rise = start & ~start_q;

`ifdef MUSEDASH_PAUSE_EN
  logic pause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= pause;
    end
  end

  assign pause_rise = pause & ~pause_q;
`else
  logic pause_unused;

  assign pause_unused = pause;
  assign pause_rise   = 1'b0;
`endif

  // A new start press restarts the chart from any state except an ongoing clear.
  assign go_clear = start_rise && (state_reg != S_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      count_reg <= '0;
      clr_reg   <= '0;
      step_reg  <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
      clr_reg   <= clr_next;
      step_reg  <= step_next;
      start_q   <= start;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    clr_next   = clr_reg;
    step_next  = 1'b0;
    case (state_reg)
      S_IDLE: ;
      S_CLEAR: begin
        clr_next = clr_reg + 1'b1;
        if (clr_reg == CLR_LAST) begin
          state_next = S_COUNT;
          count_next = COUNT_INIT;
          clr_next   = '0;
        end
      end
      S_COUNT: begin
        if (beat_tick) begin
          if (count_reg == 4'd1) begin
            state_next = S_PLAY;
            count_next = 4'd0;
          end else begin
            count_next = count_reg - 4'd1;
          end
        end
      end
      S_PLAY: begin
        if (beat_tick) begin
          step_next = 1'b1;
          // The index saturates on the last chart address; a chart_end marker earlier still advances it.
          if (idx_reg != LAST_IDX) begin
            idx_next = idx_reg + 1'b1;
          end
          if ((idx_reg == LAST_IDX) || chart_end) begin
            state_next = S_DONE;
          end else if (pause_rise) begin
            state_next = S_PAUSE;
          end
        end else if (pause_rise) begin
          state_next = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_rise) begin
          state_next = S_COUNT;
          count_next = COUNT_INIT;
        end
      end
      S_DONE: ;
      default: state_next = S_IDLE;
    endcase

    if (go_clear) begin
      state_next = S_CLEAR;
      idx_next   = '0;
      count_next = '0;
      clr_next   = '0;
      step_next  = 1'b0;
    end
  end

  assign beat_step = step_reg;
  assign dp_clr_n  = (state_reg != S_CLEAR);
  assign beat_idx  = idx_reg;
  assign count_val = count_reg;
  assign state     = state_reg;
  assign done      = (state_reg == S_DONE);

endmodule
